// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures decoded fields with WB write-through bypass,
// detects load-use hazards, inserts bubbles on stall/flush and counts both events.
module id_ex_stage_reg #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_rdata1,
  input  logic [XLEN-1:0]   id_rdata2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_write,
  input  logic              wb_reg_write,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  input  logic              ex_flush,
  output logic              stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_rdata1,
  output logic [XLEN-1:0]   ex_rdata2,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic              ex_reg_write,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  logic            haz;
  logic            byp1;
  logic            byp2;
  logic            bubble;
  logic [XLEN-1:0] fwd1;
  logic [XLEN-1:0] fwd2;

  always_comb begin
    haz = id_valid & ex_valid & ex_mem_read & (ex_rd != 5'd0) &
          ((id_uses_rs1 & (ex_rd == id_rs1)) | (id_uses_rs2 & (ex_rd == id_rs2)));
    // Flush kills the consumer, so no stall is needed; reset also masks it.
    stall  = haz & ~ex_flush & ~reset;
    bubble = ex_flush | stall;
    // Register file writes on the same edge, so its read port would return stale data.
    byp1   = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == id_rs1);
    byp2   = wb_reg_write & (wb_rd != 5'd0) & (wb_rd == id_rs2);
    fwd1   = byp1 ? wb_data : id_rdata1;
    fwd2   = byp2 ? wb_data : id_rdata2;
  end

  always_ff @(posedge clk) begin
    if (reset || bubble) begin
      ex_valid     <= 1'b0;
      ex_pc        <= '0;
      ex_rs1       <= '0;
      ex_rs2       <= '0;
      ex_rd        <= '0;
      ex_rdata1    <= '0;
      ex_rdata2    <= '0;
      ex_imm       <= '0;
      ex_ctrl      <= '0;
      ex_mem_read  <= 1'b0;
      ex_reg_write <= 1'b0;
    end else begin
      ex_valid     <= id_valid;
      ex_pc        <= id_pc;
      ex_rs1       <= id_rs1;
      ex_rs2       <= id_rs2;
      ex_rd        <= id_rd;
      ex_rdata1    <= fwd1;
      ex_rdata2    <= fwd2;
      ex_imm       <= id_imm;
      ex_ctrl      <= id_valid ? id_ctrl : '0;
      ex_mem_read  <= id_valid & id_mem_read;
      ex_reg_write <= id_valid & id_reg_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
      if (ex_flush && (flush_cnt != '1)) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed bench for id_ex_stage_reg: scoreboard of expected EX bundles plus
// direct checks of stall and the saturating counters (CNT_W=4).
module tb_id_ex_stage_reg;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] imm;
    logic [7:0]  ctrl;
    logic        mem_read;
    logic        reg_write;
  } ex_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        id_valid = 1'b0;
  logic [31:0] id_pc = '0;
  logic [4:0]  id_rs1 = '0;
  logic [4:0]  id_rs2 = '0;
  logic        id_uses_rs1 = 1'b0;
  logic        id_uses_rs2 = 1'b0;
  logic [4:0]  id_rd = '0;
  logic [31:0] id_rdata1 = '0;
  logic [31:0] id_rdata2 = '0;
  logic [31:0] id_imm = '0;
  logic [7:0]  id_ctrl = '0;
  logic        id_mem_read = 1'b0;
  logic        id_reg_write = 1'b0;
  logic        wb_reg_write = 1'b0;
  logic [4:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        ex_flush = 1'b0;
  logic        stall;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic [31:0] ex_rdata1;
  logic [31:0] ex_rdata2;
  logic [31:0] ex_imm;
  logic [7:0]  ex_ctrl;
  logic        ex_mem_read;
  logic        ex_reg_write;
  logic [3:0]  stall_cnt;
  logic [3:0]  flush_cnt;

  ex_t sb[$];
  int  checks = 0;
  int  failures = 0;
  int  exp_sc = 0;
  int  exp_fc = 0;

  id_ex_stage_reg #(.XLEN(32), .CTRL_W(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .id_rd(id_rd),
    .id_rdata1(id_rdata1), .id_rdata2(id_rdata2), .id_imm(id_imm), .id_ctrl(id_ctrl),
    .id_mem_read(id_mem_read), .id_reg_write(id_reg_write),
    .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_data(wb_data), .ex_flush(ex_flush),
    .stall(stall), .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  task automatic chk_ex(input string tag);
    ex_t obs;
    ex_t req;
    obs = {ex_valid, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_rdata1, ex_rdata2, ex_imm,
           ex_ctrl, ex_mem_read, ex_reg_write};
    checks++;
    assert (sb.size() != 0) else begin
      failures++;
      $error("FAIL %s observed=%h expected=<scoreboard empty>", tag, obs);
      return;
    end
    req = sb.pop_front();
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, req);
    end
  endtask

  task automatic set_id(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic u1, input logic u2,
                        input logic [4:0] rd, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] imm, input logic [7:0] ctrl,
                        input logic mr, input logic rw);
    id_valid = v;     id_pc = pc;       id_rs1 = rs1;   id_rs2 = rs2;
    id_uses_rs1 = u1; id_uses_rs2 = u2; id_rd = rd;     id_rdata1 = d1;
    id_rdata2 = d2;   id_imm = imm;     id_ctrl = ctrl; id_mem_read = mr;
    id_reg_write = rw;
    #1;
  endtask

  // Expected EX bundle for a valid instruction issued with the given operand values.
  function automatic ex_t issued(input logic [31:0] d1, input logic [31:0] d2);
    return {1'b1, id_pc, id_rs1, id_rs2, id_rd, d1, d2, id_imm, id_ctrl,
            id_mem_read, id_reg_write};
  endfunction

  initial begin
    // Reset
    tick();
    sb.push_back('0);
    tick();
    chk_ex("reset_ex");
    chk("reset_stall", 32'(stall), 32'd0);
    chk("reset_stall_cnt", 32'(stall_cnt), 32'd0);
    chk("reset_flush_cnt", 32'(flush_cnt), 32'd0);
    reset = 1'b0;

    // 1: load x5 then dependent add -> one stall, bubble, then add issues
    set_id(1, 32'h100, 5'd1, 5'd2, 1, 0, 5'd5, 32'h11, 32'h22, 32'h4, 8'h5A, 1, 1);
    chk("load_no_stall", 32'(stall), 32'd0);
    sb.push_back(issued(32'h11, 32'h22));
    tick();
    chk_ex("load_issue");
    set_id(1, 32'h104, 5'd5, 5'd6, 1, 1, 5'd8, 32'h33, 32'h44, 32'h0, 8'h21, 0, 1);
    chk("load_use_stall", 32'(stall), 32'd1);
    sb.push_back('0);
    tick();
    exp_sc++;
    chk_ex("load_use_bubble");
    chk("stall_cnt_1", 32'(stall_cnt), 32'(exp_sc));
    chk("stall_drops", 32'(stall), 32'd0);
    sb.push_back(issued(32'h33, 32'h44));
    tick();
    chk_ex("add_issue");

    // 2: WB->ID bypass on rs2
    wb_reg_write = 1'b1; wb_rd = 5'd7; wb_data = 32'hDEADBEEF;
    set_id(1, 32'h108, 5'd3, 5'd7, 1, 1, 5'd9, 32'h55, 32'h0, 32'h8, 8'h03, 0, 1);
    chk("bypass_no_stall", 32'(stall), 32'd0);
    sb.push_back(issued(32'h55, 32'hDEADBEEF));
    tick();
    chk_ex("bypass_rs2");

    // 3: x0 never bypassed; load with rd=0 never stalls
    wb_rd = 5'd0; wb_data = 32'h1234;
    set_id(1, 32'h10C, 5'd0, 5'd0, 1, 1, 5'd0, 32'h0, 32'h77, 32'hC, 8'h0F, 1, 1);
    sb.push_back(issued(32'h0, 32'h77));
    tick();
    chk_ex("x0_no_bypass");
    wb_reg_write = 1'b0;
    set_id(1, 32'h110, 5'd0, 5'd0, 1, 1, 5'd10, 32'h0, 32'h0, 32'h10, 8'h11, 1, 1);
    chk("load_rd0_no_stall", 32'(stall), 32'd0);
    sb.push_back(issued(32'h0, 32'h0));
    tick();
    chk_ex("load_x10_issue");

    // 4: hazard on rs2 plus flush in the same cycle
    set_id(1, 32'h114, 5'd1, 5'd10, 0, 1, 5'd11, 32'h66, 32'h88, 32'h14, 8'h22, 0, 1);
    chk("rs2_hazard_stall", 32'(stall), 32'd1);
    ex_flush = 1'b1;
    #1;
    chk("flush_masks_stall", 32'(stall), 32'd0);
    sb.push_back('0);
    tick();
    exp_fc++;
    ex_flush = 1'b0;
    chk_ex("flush_bubble");
    chk("flush_cnt_1", 32'(flush_cnt), 32'(exp_fc));
    chk("stall_cnt_unchanged", 32'(stall_cnt), 32'(exp_sc));

    // 5: reset during a stall cycle
    set_id(1, 32'h200, 5'd1, 5'd2, 1, 1, 5'd12, 32'h1, 32'h2, 32'h0, 8'h44, 1, 1);
    sb.push_back(issued(32'h1, 32'h2));
    tick();
    chk_ex("load_x12_issue");
    set_id(1, 32'h204, 5'd12, 5'd3, 1, 1, 5'd13, 32'h5, 32'h6, 32'h0, 8'h45, 0, 1);
    chk("pre_reset_stall", 32'(stall), 32'd1);
    reset = 1'b1;
    #1;
    chk("reset_masks_stall", 32'(stall), 32'd0);
    sb.push_back('0);
    tick();
    exp_sc = 0;
    exp_fc = 0;
    reset = 1'b0;
    chk_ex("reset_mid_stall_ex");
    chk("reset_mid_stall_sc", 32'(stall_cnt), 32'd0);
    chk("reset_mid_stall_fc", 32'(flush_cnt), 32'd0);
    chk("post_reset_stall", 32'(stall), 32'd0);

    // rs2 match without id_uses_rs2 is not a hazard
    set_id(1, 32'h400, 5'd1, 5'd2, 1, 0, 5'd13, 32'h7, 32'h8, 32'h0, 8'h46, 1, 1);
    sb.push_back(issued(32'h7, 32'h8));
    tick();
    chk_ex("load_x13_issue");
    set_id(1, 32'h404, 5'd2, 5'd13, 1, 0, 5'd14, 32'h9, 32'hA, 32'h0, 8'h47, 0, 1);
    chk("unused_rs2_no_stall", 32'(stall), 32'd0);
    sb.push_back(issued(32'h9, 32'hA));
    tick();
    chk_ex("unused_rs2_issue");

    // Invalid ID slot: control cleared, data fields still captured
    set_id(0, 32'h408, 5'd3, 5'd4, 1, 1, 5'd15, 32'hAA, 32'hBB, 32'hCC, 8'hFF, 1, 1);
    sb.push_back({1'b0, 32'h408, 5'd3, 5'd4, 5'd15, 32'hAA, 32'hBB, 32'hCC, 8'h00,
                  1'b0, 1'b0});
    tick();
    chk_ex("invalid_slot");

    // 6: 20 consecutive flushes saturate the 4-bit counter at 15
    set_id(1, 32'h500, 5'd1, 5'd2, 1, 1, 5'd3, 32'h1, 32'h2, 32'h3, 8'h48, 0, 1);
    ex_flush = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sb.push_back('0);
      tick();
      if (exp_fc < 15) exp_fc++;
      chk_ex("sat_flush_bubble");
      chk("sat_flush_cnt", 32'(flush_cnt), 32'(exp_fc));
    end
    ex_flush = 1'b0;
    chk("flush_cnt_saturated", 32'(flush_cnt), 32'd15);
    chk("stall_cnt_after_flushes", 32'(stall_cnt), 32'(exp_sc));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
